// File: rtl/tdm_pkg.sv
// Shared parameters, derived widths and FSM encoding for the ST-bus frame scheduler.
package tdm_pkg;

  localparam int C4_PER_BIT    = 2;
  localparam int BITS_PER_SLOT = 8;
  localparam int SLOTS         = 32;
  localparam int LOCK_FRAMES   = 2;
  localparam int MISS_LIMIT    = 2;

  localparam int C4_PER_FRAME = C4_PER_BIT * BITS_PER_SLOT * SLOTS;

  localparam int POS_W   = $clog2(C4_PER_FRAME);
  localparam int PHASE_W = $clog2(C4_PER_BIT);
  localparam int BIT_W   = $clog2(BITS_PER_SLOT);
  localparam int SLOT_W  = $clog2(SLOTS);
  localparam int OK_W    = $clog2(LOCK_FRAMES + 1);
  localparam int MISS_W  = $clog2(MISS_LIMIT + 1);

  localparam logic [POS_W-1:0] POS_LAST = POS_W'(C4_PER_FRAME - 1);

  localparam int CAUSE_FRAME     = 0;
  localparam int CAUSE_LOCK_LOST = 1;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } fsm_state_t;

endpackage

// File: rtl/st_sync_edge.sv
// Two-flop synchroniser for an asynchronous ST-bus pin, with an optional
// registered rising-edge strobe (pin edge to strobe is three clk50 cycles).
module st_sync_edge #(
  parameter bit EDGE_EN = 1'b1
) (
  input  logic clk50,
  input  logic reset_rg_n,
  input  logic din,
  output logic level,
  output logic rise
);

  logic meta;
  logic sync;

  always_ff @(posedge clk50 or negedge reset_rg_n) begin
    if (!reset_rg_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
    end else begin
      meta <= din;
      sync <= meta;
    end
  end

  assign level = sync;

  generate
    if (EDGE_EN) begin : g_edge
      logic dly;
      logic rise_q;

      always_ff @(posedge clk50 or negedge reset_rg_n) begin
        if (!reset_rg_n) begin
          dly    <= 1'b0;
          rise_q <= 1'b0;
        end else begin
          dly    <= sync;
          rise_q <= sync & ~dly;
        end
      end

      assign rise = rise_q;
    end else begin : g_no_edge
      assign rise = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/tdm_frame_scheduler.sv
// ST-bus frame/timeslot scheduler: hunts and verifies f0 alignment, then tracks
// slot/bit position, drives datapath strobes and raises frame/lock interrupts.
//
// state     | meaning
// ST_HUNT   | no alignment; pos held at 0, any marker starts a candidate frame
// ST_VERIFY | candidate alignment; counting correctly placed markers
// ST_LOCKED | alignment valid; strobes and route enables active
module tdm_frame_scheduler
  import tdm_pkg::*;
(
  input  logic              clk50,
  input  logic              reset_rg_n,
  input  logic              c4,
  input  logic              f0,
  input  logic [SLOTS-1:0]  slot_mask,
  input  logic              int_ack,
  output logic              c4_rise,
  output logic              bit_drive,
  output logic              bit_sample,
  output logic [SLOT_W-1:0] slot_num,
  output logic [BIT_W-1:0]  bit_num,
  output logic              slot_active,
  output logic              frame_start,
  output logic              locked,
  output logic              cpu_int,
  output logic [1:0]        int_cause,
  output logic [7:0]        frame_err_cnt
);

  logic c4_level_unused;
  logic f0_rise_unused;
  logic f0_s;

  st_sync_edge #(.EDGE_EN(1'b1)) u_c4_sync (
    .clk50      (clk50),
    .reset_rg_n (reset_rg_n),
    .din        (c4),
    .level      (c4_level_unused),
    .rise       (c4_rise)
  );

  st_sync_edge #(.EDGE_EN(1'b0)) u_f0_sync (
    .clk50      (clk50),
    .reset_rg_n (reset_rg_n),
    .din        (f0),
    .level      (f0_s),
    .rise       (f0_rise_unused)
  );

  fsm_state_t         state, state_nxt;
  logic [POS_W-1:0]   pos, pos_nxt;
  logic [OK_W-1:0]    ok_cnt, ok_nxt;
  logic [MISS_W-1:0]  miss_cnt, miss_nxt;
  logic [SLOTS-1:0]   shadow_mask;
  logic               marker;
  logic               at_last;
  logic               err_inc;
  logic               fs_set;
  logic               lost_set;
  logic               locked_nxt;
  logic [1:0]         cause_set;
  logic [1:0]         cause_nxt;
  logic [PHASE_W-1:0] phase_nxt;

  assign marker  = c4_rise & ~f0_s;
  assign at_last = (pos == POS_LAST);

  always_comb begin
    state_nxt = state;
    pos_nxt   = pos;
    ok_nxt    = ok_cnt;
    miss_nxt  = miss_cnt;
    err_inc   = 1'b0;
    fs_set    = 1'b0;
    lost_set  = 1'b0;
    if (c4_rise) begin
      unique case (state)
        ST_HUNT: begin
          if (marker) begin
            state_nxt = ST_VERIFY;
            pos_nxt   = '0;
            ok_nxt    = '0;
          end
        end
        ST_VERIFY: begin
          if (marker && at_last) begin
            pos_nxt = '0;
            ok_nxt  = ok_cnt + 1'b1;
            if (ok_cnt == OK_W'(LOCK_FRAMES - 1)) begin
              state_nxt = ST_LOCKED;
              miss_nxt  = '0;
              fs_set    = 1'b1;
            end
          end else if (marker) begin
            pos_nxt = '0;
            ok_nxt  = '0;
          end else if (at_last) begin
            state_nxt = ST_HUNT;
            pos_nxt   = '0;
          end else begin
            pos_nxt = pos + 1'b1;
          end
        end
        ST_LOCKED: begin
          // A misplaced marker is counted as an error but never realigns pos.
          pos_nxt = at_last ? '0 : pos + 1'b1;
          if (marker && at_last) begin
            miss_nxt = '0;
          end else if (marker || at_last) begin
            miss_nxt = miss_cnt + 1'b1;
            err_inc  = 1'b1;
          end
          if (miss_nxt == MISS_W'(MISS_LIMIT)) begin
            state_nxt = ST_HUNT;
            pos_nxt   = '0;
            lost_set  = 1'b1;
          end else if (at_last) begin
            fs_set = 1'b1;
          end
        end
        default: begin
          state_nxt = ST_HUNT;
          pos_nxt   = '0;
        end
      endcase
    end
  end

  always_comb begin
    cause_set                  = 2'b00;
    cause_set[CAUSE_FRAME]     = fs_set;
    cause_set[CAUSE_LOCK_LOST] = lost_set;
    // Acknowledge clears first so a same-cycle event still lands.
    cause_nxt  = (int_ack ? 2'b00 : int_cause) | cause_set;
    locked_nxt = (state_nxt == ST_LOCKED);
    phase_nxt  = pos_nxt[PHASE_W-1:0];
  end

  always_ff @(posedge clk50 or negedge reset_rg_n) begin
    if (!reset_rg_n) begin
      state         <= ST_HUNT;
      pos           <= '0;
      ok_cnt        <= '0;
      miss_cnt      <= '0;
      frame_err_cnt <= 8'd0;
      shadow_mask   <= '0;
      bit_drive     <= 1'b0;
      bit_sample    <= 1'b0;
      frame_start   <= 1'b0;
      int_cause     <= 2'b00;
      cpu_int       <= 1'b0;
    end else begin
      state       <= state_nxt;
      pos         <= pos_nxt;
      ok_cnt      <= ok_nxt;
      miss_cnt    <= miss_nxt;
      bit_drive   <= c4_rise & locked_nxt & (phase_nxt == '0);
      bit_sample  <= c4_rise & locked_nxt & (phase_nxt == PHASE_W'(C4_PER_BIT - 1));
      frame_start <= fs_set;
      int_cause   <= cause_nxt;
      cpu_int     <= |cause_nxt;
      if (fs_set) begin
        shadow_mask <= slot_mask;
      end
      if (err_inc && (frame_err_cnt != 8'hFF)) begin
        frame_err_cnt <= frame_err_cnt + 8'd1;
      end
    end
  end

  assign locked      = (state == ST_LOCKED);
  assign slot_num    = pos[POS_W-1 -: SLOT_W];
  assign bit_num     = pos[PHASE_W +: BIT_W];
  assign slot_active = locked & shadow_mask[slot_num];

endmodule

// File: tb/tb_tdm_frame_scheduler.sv
// Bench for tdm_frame_scheduler: segment table with hand-derived end states plus
// a per-c4-edge reference model feeding a scoreboard queue.
module tb_tdm_frame_scheduler;

  localparam int FRAME   = 512;
  localparam int PER_SLT = 16;
  localparam int M_HUNT   = 0;
  localparam int M_VERIFY = 1;
  localparam int M_LOCKED = 2;

  logic        clk50;
  logic        reset_rg_n;
  logic        c4;
  logic        f0;
  logic [31:0] slot_mask;
  logic        int_ack;
  logic        c4_rise;
  logic        bit_drive;
  logic        bit_sample;
  logic [4:0]  slot_num;
  logic [2:0]  bit_num;
  logic        slot_active;
  logic        frame_start;
  logic        locked;
  logic        cpu_int;
  logic [1:0]  int_cause;
  logic [7:0]  frame_err_cnt;

  tdm_frame_scheduler dut (
    .clk50         (clk50),
    .reset_rg_n    (reset_rg_n),
    .c4            (c4),
    .f0            (f0),
    .slot_mask     (slot_mask),
    .int_ack       (int_ack),
    .c4_rise       (c4_rise),
    .bit_drive     (bit_drive),
    .bit_sample    (bit_sample),
    .slot_num      (slot_num),
    .bit_num       (bit_num),
    .slot_active   (slot_active),
    .frame_start   (frame_start),
    .locked        (locked),
    .cpu_int       (cpu_int),
    .int_cause     (int_cause),
    .frame_err_cnt (frame_err_cnt)
  );

  initial clk50 = 1'b0;
  always #10 clk50 = ~clk50;

  typedef struct packed {
    logic       locked;
    logic [4:0] slot;
    logic [2:0] bitn;
    logic       drv;
    logic       smp;
    logic       fs;
    logic       act;
    logic [1:0] cause;
    logic       cpu;
    logic [7:0] err;
  } snap_t;

  typedef struct {
    string name;
    int    ticks;
    int    mk_at;
    bit    ack_before;
    bit    exp_locked;
    int    exp_err;
    int    exp_cause;
    bit    exp_cpu;
    int    exp_fs;
    int    exp_drv;
    int    exp_smp;
  } seg_t;

  int n_checks = 0;
  int n_fail   = 0;

  int fs_cnt  = 0;
  int drv_cnt = 0;
  int smp_cnt = 0;

  always @(posedge clk50) begin
    #1;
    fs_cnt  += int'(frame_start);
    drv_cnt += int'(bit_drive);
    smp_cnt += int'(bit_sample);
  end

  int          m_state;
  int          m_pos;
  int          m_ok;
  int          m_miss;
  int          m_err;
  logic [31:0] m_shadow;
  logic [1:0]  m_cause;
  snap_t       sb_q[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state  = M_HUNT;
    m_pos    = 0;
    m_ok     = 0;
    m_miss   = 0;
    m_err    = 0;
    m_shadow = 32'h0;
    m_cause  = 2'b00;
  endtask

  task automatic model_step(input bit mk, input bit ack, output snap_t e);
    bit wrap;
    bit fs;
    bit lost;
    wrap = (m_pos == FRAME - 1);
    fs   = 1'b0;
    lost = 1'b0;
    case (m_state)
      M_HUNT: begin
        if (mk) begin
          m_state = M_VERIFY;
          m_pos   = 0;
          m_ok    = 0;
        end
      end
      M_VERIFY: begin
        if (mk && wrap) begin
          m_pos = 0;
          m_ok++;
          if (m_ok >= 2) begin
            m_state = M_LOCKED;
            m_miss  = 0;
            fs      = 1'b1;
          end
        end else if (mk) begin
          m_pos = 0;
          m_ok  = 0;
        end else if (wrap) begin
          m_state = M_HUNT;
          m_pos   = 0;
        end else begin
          m_pos++;
        end
      end
      default: begin
        m_pos = wrap ? 0 : m_pos + 1;
        if (mk && wrap) begin
          m_miss = 0;
        end else if (mk || wrap) begin
          m_miss++;
          if (m_err < 255) m_err++;
        end
        if (m_miss >= 2) begin
          m_state = M_HUNT;
          m_pos   = 0;
          lost    = 1'b1;
        end else if (wrap) begin
          fs = 1'b1;
        end
      end
    endcase
    if (fs) m_shadow = slot_mask;
    m_cause  = (ack ? 2'b00 : m_cause) | {lost, fs};
    e.locked = (m_state == M_LOCKED);
    e.slot   = 5'(m_pos / PER_SLT);
    e.bitn   = 3'((m_pos / 2) % 8);
    e.drv    = e.locked && (m_pos % 2 == 0);
    e.smp    = e.locked && (m_pos % 2 == 1);
    e.fs     = fs;
    e.act    = e.locked && m_shadow[m_pos / PER_SLT];
    e.cause  = m_cause;
    e.cpu    = |m_cause;
    e.err    = 8'(m_err);
  endtask

  function automatic snap_t dut_snap();
    snap_t s;
    s.locked = locked;
    s.slot   = slot_num;
    s.bitn   = bit_num;
    s.drv    = bit_drive;
    s.smp    = bit_sample;
    s.fs     = frame_start;
    s.act    = slot_active;
    s.cause  = int_cause;
    s.cpu    = cpu_int;
    s.err    = frame_err_cnt;
    return s;
  endfunction

  // One c4 period (2 clk50 high, 2 low), starting and ending on a falling clk50 edge.
  task automatic tick(input bit mk, input bit ack);
    snap_t e;
    c4 = 1'b1;
    f0 = ~mk;
    model_step(mk, ack, e);
    sb_q.push_back(e);
    @(negedge clk50);
    @(negedge clk50);
    chk("c4_rise_early", 32'(c4_rise), 32'd0);
    c4 = 1'b0;
    @(negedge clk50);
    chk("c4_rise_latency", 32'(c4_rise), 32'd1);
    int_ack = ack;
    @(negedge clk50);
    int_ack = 1'b0;
    f0      = 1'b1;
    e = sb_q.pop_front();
    chk("snapshot", 32'(dut_snap()), 32'(e));
  endtask

  task automatic run(input int n, input bit mk_last);
    for (int i = 0; i < n; i++) tick(mk_last && (i == n - 1), 1'b0);
  endtask

  task automatic ack_pulse();
    int_ack = 1'b1;
    @(negedge clk50);
    int_ack = 1'b0;
    m_cause = 2'b00;
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({c4_rise, bit_drive, bit_sample, slot_num, bit_num, slot_active,
                frame_start, locked, cpu_int, int_cause, frame_err_cnt});
  endfunction

  seg_t segs[11];

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int f_s, d_s, s_s;

    segs[0]  = '{"hunt_idle",     5,   0, 1'b0, 1'b0, 0, 0, 1'b0, 0, 0,   0};
    segs[1]  = '{"first_marker",  1,   1, 1'b0, 1'b0, 0, 0, 1'b0, 0, 0,   0};
    segs[2]  = '{"verify_ok1",    512, 512, 1'b0, 1'b0, 0, 0, 1'b0, 0, 0,   0};
    segs[3]  = '{"lock",          512, 512, 1'b0, 1'b1, 0, 1, 1'b1, 1, 1,   0};
    segs[4]  = '{"clean_frame",   512, 512, 1'b0, 1'b1, 0, 1, 1'b1, 1, 256, 256};
    segs[5]  = '{"miss_one",      512, 0,   1'b1, 1'b1, 1, 1, 1'b1, 1, 256, 256};
    segs[6]  = '{"miss_two",      512, 0,   1'b1, 1'b0, 2, 2, 1'b1, 0, 255, 256};
    segs[7]  = '{"rehunt_marker", 1,   1,   1'b1, 1'b0, 2, 0, 1'b0, 0, 0,   0};
    segs[8]  = '{"early_marker",  509, 509, 1'b0, 1'b0, 2, 0, 1'b0, 0, 0,   0};
    segs[9]  = '{"verify_ok1b",   512, 512, 1'b0, 1'b0, 2, 0, 1'b0, 0, 0,   0};
    segs[10] = '{"relock",        512, 512, 1'b0, 1'b1, 2, 1, 1'b1, 1, 1,   0};

    reset_rg_n = 1'b0;
    c4         = 1'b0;
    f0         = 1'b1;
    slot_mask  = 32'hFFFF_0000;
    int_ack    = 1'b0;
    model_reset();
    repeat (3) @(negedge clk50);
    chk("reset_outputs", all_outs(), 32'd0);
    reset_rg_n = 1'b1;

    for (int s = 0; s < 11; s++) begin
      if (segs[s].ack_before) ack_pulse();
      f_s = fs_cnt;
      d_s = drv_cnt;
      s_s = smp_cnt;
      for (int i = 1; i <= segs[s].ticks; i++) tick(i == segs[s].mk_at, 1'b0);
      chk({segs[s].name, "_state"}, 32'({locked, frame_err_cnt, int_cause, cpu_int}),
          32'({segs[s].exp_locked, 8'(segs[s].exp_err), 2'(segs[s].exp_cause), segs[s].exp_cpu}));
      chk({segs[s].name, "_frame_starts"}, 32'(fs_cnt - f_s), 32'(segs[s].exp_fs));
      chk({segs[s].name, "_bit_drives"}, 32'(drv_cnt - d_s), 32'(segs[s].exp_drv));
      chk({segs[s].name, "_bit_samples"}, 32'(smp_cnt - s_s), 32'(segs[s].exp_smp));
    end

    // Acknowledge coincides with the frame_start edge: the new event must survive.
    run(511, 1'b0);
    tick(1'b1, 1'b1);
    chk("race_cause", 32'(int_cause), 32'd1);
    chk("race_cpu_int", 32'(cpu_int), 32'd1);
    ack_pulse();
    chk("race_later_ack", 32'({cpu_int, int_cause}), 32'd0);

    // Mid-frame mask write only takes effect at the next frame_start.
    run(160, 1'b0);
    slot_mask = 32'h0000_0005;
    run(160, 1'b0);
    chk("mask_old_slot20", 32'({slot_num, slot_active}), 32'({5'd20, 1'b1}));
    run(191, 1'b0);
    tick(1'b1, 1'b0);
    chk("mask_new_slot0", 32'({slot_num, slot_active}), 32'({5'd0, 1'b1}));
    run(16, 1'b0);
    chk("mask_new_slot1", 32'({slot_num, slot_active}), 32'({5'd1, 1'b0}));
    run(16, 1'b0);
    chk("mask_new_slot2", 32'({slot_num, slot_active}), 32'({5'd2, 1'b1}));
    run(240, 1'b0);
    chk("pre_reset_slot17", 32'({locked, slot_num, slot_active}), 32'({1'b1, 5'd17, 1'b0}));

    #3;
    reset_rg_n = 1'b0;
    #1;
    chk("reset_async_outputs", all_outs(), 32'd0);
    @(negedge clk50);
    @(negedge clk50);
    reset_rg_n = 1'b1;
    model_reset();

    tick(1'b1, 1'b0);
    chk("relock_after_m1", 32'(locked), 32'd0);
    run(512, 1'b1);
    chk("relock_after_m2", 32'(locked), 32'd0);
    run(512, 1'b1);
    chk("relock_after_m3", 32'({locked, int_cause}), 32'({1'b1, 2'b01}));

    // f0 stuck low: every edge is a marker, misplaced ones drop lock.
    repeat (3) tick(1'b1, 1'b0);
    chk("f0_low_state", 32'({locked, frame_err_cnt, int_cause, cpu_int}),
        32'({1'b0, 8'd2, 2'b11, 1'b1}));

    repeat (20) @(negedge clk50);
    chk("c4_stopped", 32'({locked, slot_num, bit_num, bit_drive, bit_sample, frame_start,
                           frame_err_cnt, int_cause, cpu_int}),
        32'({1'b0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0, 8'd2, 2'b11, 1'b1}));
    run(3, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tdm_frame_scheduler.md
Name: tdm_frame_scheduler

Overview:
- Frame/timeslot scheduler for the ST-bus side of the converter.
- Runs on clk50 and oversamples the c4 bit clock and the f0 frame pulse.
- Hunts for and verifies frame alignment, then tracks slot/bit position.
- Issues per-bit drive/sample strobes and per-slot route enables to the DT/STM shift datapath, and raises cpu_int on frame completion or loss of lock.

Parameters:
- C4_PER_BIT, 2: c4 rising edges per ST-bus bit.
- BITS_PER_SLOT, 8: bits per timeslot.
- SLOTS, 32: timeslots per frame.
- LOCK_FRAMES, 2: consecutive correctly placed markers required to declare lock.
- MISS_LIMIT, 2: consecutive bad/missing markers that drop lock.

Ports:
- clk50  in  1  system clock, 50 MHz.
- reset_rg_n  in  1  asynchronous active-low reset.
- c4  in  1  asynchronous ST-bus clock, 4.096 MHz.
- f0  in  1  asynchronous frame pulse, active low.
- slot_mask  in  SLOTS  1 = route this slot.
- int_ack  in  1  one-clk50 pulse that clears cpu_int.
- c4_rise  out  1  one-cycle strobe per c4 rising edge.
- bit_drive  out  1  strobe at the first c4 edge of each bit.
- bit_sample  out  1  strobe at the last c4 edge of each bit.
- slot_num  out  $clog2(SLOTS)  current slot.
- bit_num  out  $clog2(BITS_PER_SLOT)  current bit in slot.
- slot_active  out  1  locked AND shadow mask bit for slot_num.
- frame_start  out  1  strobe when the position counter wraps to 0 while locked.
- locked  out  1  frame alignment valid.
- cpu_int  out  1  sticky interrupt.
- int_cause  out  2  bit0 = frame done, bit1 = lock lost.
- frame_err_cnt  out  8  saturating miss counter.

Behaviour:
- Reset (asynchronous, reset_rg_n low):
  - All outputs 0.
  - FSM in HUNT; all counters 0; shadow mask 0.
  - Reset mid-operation discards alignment.
- Input synchronisation:
  - c4 and f0 each pass through a 2-FF synchroniser.
  - c4 gets a third FF for rising-edge detect.
  - c4_rise fires 3 clk50 cycles after the pin edge, one cycle wide.
- Position counter:
  - pos counts 0..C4_PER_FRAME-1, where C4_PER_FRAME = C4_PER_BIT*BITS_PER_SLOT*SLOTS (512 by default).
  - pos advances only on c4_rise.
  - A marker is a c4_rise with synchronised f0 == 0.
  - "Expected" means the marker occurs while pos == C4_PER_FRAME-1.
- Derived position (defaults):
  - phase = pos[0]; bit_num = pos[3:1]; slot_num = pos[8:4].
- FSM states HUNT, VERIFY, LOCKED:
  - HUNT: on any marker, pos <= 0, ok_cnt <= 0, go to VERIFY. Otherwise pos is held at 0.
  - VERIFY, expected marker: pos wraps to 0 and ok_cnt increments. If ok_cnt reaches LOCK_FRAMES, go to LOCKED.
  - VERIFY, marker at any other pos: pos <= 0, ok_cnt <= 0, stay in VERIFY.
  - VERIFY, wrap with no marker: go to HUNT.
  - LOCKED, expected marker: miss_cnt <= 0.
  - LOCKED, no marker at wrap, or misplaced marker: increment miss_cnt and frame_err_cnt (saturate at 255). pos free-runs and the misplaced marker does not realign it.
  - LOCKED, miss_cnt reaches MISS_LIMIT: go to HUNT, locked <= 0, set int_cause[1].
- Strobes (only while LOCKED, all registered one cycle after c4_rise):
  - bit_drive on phase 0.
  - bit_sample on phase C4_PER_BIT-1.
- Shadow mask:
  - slot_mask is copied into the shadow register on the cycle frame_start is generated.
  - Mid-frame changes to slot_mask take effect from the next frame.
- Interrupt:
  - frame_start sets int_cause[0].
  - cpu_int = |int_cause, registered.
  - int_ack clears both int_cause bits.
  - Set and ack in the same cycle: set wins.
- Edge cases:
  - c4 stopped: no state change.
  - f0 held low: a marker on every edge; these count as misplaced except at wrap.

Decomposition:
- Package tdm_pkg holds:
  - FSM enum (HUNT, VERIFY, LOCKED).
  - C4_PER_FRAME and derived widths.
  - int_cause bit indices.
- One sub-module: st_sync_edge, a 2-FF synchroniser plus optional edge detect.
  - Instantiated for c4 (edge) and f0 (level).
- The FSM, counters, mask and interrupt logic stay in the top.

Test Plan:
- Clean lock: f0 low once every 512 c4 edges.
  - locked rises after the 3rd marker.
  - slot_num steps 0..31; bit_num 0..7 with bit_drive/bit_sample alternating.
  - frame_start once per 512 c4 edges.
- Mask latch: write slot_mask = 0x00000005 at slot 10 of a locked frame.
  - Current frame uses the old mask.
  - From the next frame_start, slot_active is high only in slots 0 and 2.
- Marker loss:
  - One missing marker: locked stays 1, frame_err_cnt = 1.
  - Two consecutive missing markers: locked = 0, frame_err_cnt = 2, cpu_int = 1, int_cause = 2'b10 (plus bit0 if unacked).
- Misaligned verify: in VERIFY, place a marker 3 c4 edges early.
  - pos restarts at 0, ok_cnt = 0.
  - Lock needs two further correct markers.
- Interrupt race: int_ack in the same cycle as frame_start.
  - cpu_int stays 1, int_cause[0] = 1.
  - A later int_ack clears cpu_int to 0.
- Reset mid-lock: drop reset_rg_n at slot 17.
  - All outputs 0 immediately (asynchronous).
  - After release, FSM is in HUNT and locked = 0 until the 3rd marker.
